// File: rtl/block_quant_pkg.sv
// block_quant_pkg: shared helpers for the block quantizer (MSB search, shift range, saturation bounds)
package block_quant_pkg;
  localparam int MAX_W = 64;
  function automatic int msb_index(input logic [MAX_W-1:0] v, input int width);
    int p;
    p = 0;
    for (int i = 0; i < MAX_W; i++) if (i < width && v[i]) p = i;
    return p;
  endfunction
  function automatic int shift_max(input int in_w, input int out_w);
    return (in_w - 1 - (out_w - 2)) > 0 ? in_w - 1 - (out_w - 2) : 0;
  endfunction
  function automatic int sat_hi(input int out_w);
    return (1 << (out_w - 1)) - 1;
  endfunction
  function automatic int sat_lo(input int out_w);
    return 1 - (1 << (out_w - 1));
  endfunction
endpackage

// File: rtl/block_quantizer_leading_one_detector.sv
// leading_one_detector: combinational index of the most significant one, plus an all-zero flag
module leading_one_detector
  import block_quant_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IDX_W = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             zero
);
  always_comb begin
    idx  = IDX_W'(msb_index(MAX_W'(vec), WIDTH));
    zero = vec == '0;
  end
endmodule

// File: rtl/block_quantizer.sv
// block_quantizer: two-stage block floating-point quantizer with round-half-up and symmetric saturation
module block_quantizer
  import block_quant_pkg::*;
#(
  parameter int IN_WIDTH       = 16,
  parameter int IN_SIZE        = 4,
  parameter int IN_PARALLELISM = 1,
  parameter int OUT_WIDTH      = 8,
  parameter int EXP_WIDTH      = $clog2(IN_WIDTH) + 1
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic [IN_SIZE*IN_PARALLELISM-1:0][IN_WIDTH-1:0]    data_in,
  input  logic [IN_WIDTH-1:0]                                max_num,
  input  logic                                               data_in_valid,
  output logic                                               data_in_ready,
  output logic [IN_SIZE*IN_PARALLELISM-1:0][OUT_WIDTH-1:0]   data_out,
  output logic [EXP_WIDTH-1:0]                               exp_out,
  output logic                                               sat_out,
  output logic                                               data_out_valid,
  input  logic                                               data_out_ready
);
  localparam int N     = IN_SIZE * IN_PARALLELISM;
  localparam int IDX_W = $clog2(IN_WIDTH) + 1;
  localparam int OFF   = OUT_WIDTH - 2;
  localparam int CW    = (IN_WIDTH + 1 > OUT_WIDTH ? IN_WIDTH + 1 : OUT_WIDTH) + 1;
  localparam logic signed [CW-1:0] HI = CW'(sat_hi(OUT_WIDTH));
  localparam logic signed [CW-1:0] LO = CW'(sat_lo(OUT_WIDTH));

  logic [IDX_W-1:0]             p;
  logic                         p_zero;
  logic [EXP_WIDTH-1:0]         s;
  logic                         load_b;
  logic                         va_q, va_d, vb_q, vb_d, satb_q, satb_d;
  logic [N-1:0][IN_WIDTH-1:0]   da_q, da_d;
  logic [EXP_WIDTH-1:0]         sa_q, sa_d, eb_q, eb_d;
  logic [N-1:0][OUT_WIDTH-1:0]  q, db_q, db_d;
  logic [N-1:0]                 sat;

  leading_one_detector #(.WIDTH(IN_WIDTH), .IDX_W(IDX_W)) u_lod (
    .vec  (max_num),
    .idx  (p),
    .zero (p_zero)
  );

  // Each element is widened by a guard bit so the rounding bias can never overflow.
  for (genvar g = 0; g < N; g++) begin : g_elem
    logic signed [CW-1:0] x, b, r;
    assign x      = CW'($signed(da_q[g]));
    assign b      = (sa_q != '0) ? CW'(1) << (sa_q - 1'b1) : '0;
    assign r      = (x + b) >>> sa_q;
    assign sat[g] = r > HI || r < LO;
    assign q[g]   = r > HI ? HI[OUT_WIDTH-1:0] : r < LO ? LO[OUT_WIDTH-1:0] : r[OUT_WIDTH-1:0];
  end

  always_comb begin
    s             = (!p_zero && int'(p) > OFF) ? EXP_WIDTH'(int'(p) - OFF) : '0;
    load_b        = !vb_q || data_out_ready;
    data_in_ready = !va_q || load_b;
    va_d          = data_in_ready ? data_in_valid : va_q;
    da_d          = (data_in_ready && data_in_valid) ? data_in : da_q;
    sa_d          = (data_in_ready && data_in_valid) ? s : sa_q;
    vb_d          = load_b ? va_q : vb_q;
    db_d          = (load_b && va_q) ? q : db_q;
    eb_d          = (load_b && va_q) ? sa_q : eb_q;
    satb_d        = (load_b && va_q) ? |sat : satb_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      va_q   <= 1'b0;
      vb_q   <= 1'b0;
      da_q   <= '0;
      sa_q   <= '0;
      db_q   <= '0;
      eb_q   <= '0;
      satb_q <= 1'b0;
    end else begin
      va_q   <= va_d;
      vb_q   <= vb_d;
      da_q   <= da_d;
      sa_q   <= sa_d;
      db_q   <= db_d;
      eb_q   <= eb_d;
      satb_q <= satb_d;
    end
  end

  assign data_out       = db_q;
  assign exp_out        = eb_q;
  assign sat_out        = satb_q;
  assign data_out_valid = vb_q;
endmodule
